coin_acceptor: RTL and testbench

Front-end coin acceptor that sits directly upstream of the vending machine controller. It synchronizes and debounces the raw 5- and 10-unit coin sensor lines and queues accepted coins in a small FIFO. It replays each coin to the controller as a single-cycle `five_pulse` or `ten_pulse`, so the controller never sees a bounce, a double count, or both denominations in one cycle. Coins that arrive while acceptance is disabled or the queue is full are signalled on `coin_reject` for mechanical return.

---
 rtl/coin_acceptor.sv | 150 +++++++++++++++
 tb/tb_coin_acceptor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: sync + debounce per channel, small coin queue,
// and paced single-cycle five/ten pulses toward the vending controller.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic hit
);

  typedef enum logic {IDLE, HELD} state_t;

  localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [1:0] sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hit      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!sync[1]) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          hit      = 1'b1;
          state_nx = HELD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HELD: begin
        if (sync[1]) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       accept_en,
  output logic       five_pulse,
  output logic       ten_pulse,
  output logic       coin_reject,
  output logic [3:0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic                  hit5;
  logic                  hit10;
  logic                  acc5;
  logic                  acc10;
  logic                  rd;
  logic                  code;
  logic [4:0]            free;
  logic [2:0]            gap;
  logic [AW-1:0]         wp;
  logic [AW-1:0]         wp_ten;
  logic [AW-1:0]         rp;
  logic [FIFO_DEPTH-1:0] mem;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_five (
    .clock (clock),
    .reset (reset),
    .raw   (coin5_raw),
    .hit   (hit5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ten (
    .clock (clock),
    .reset (reset),
    .raw   (coin10_raw),
    .hit   (hit10)
  );

  // A slot being read this cycle is already free for a write.
  always_comb begin
    rd     = (fifo_level != 4'd0) && (gap == 3'd0);
    code   = mem[rp];
    free   = 5'(FIFO_DEPTH) - 5'(fifo_level) + 5'(rd);
    acc5   = hit5 && accept_en && (free != 5'd0);
    acc10  = hit10 && accept_en && (free > 5'(acc5));
    wp_ten = wp + AW'(acc5);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem         <= '0;
      wp          <= '0;
      rp          <= '0;
      fifo_level  <= '0;
      gap         <= '0;
      five_pulse  <= 1'b0;
      ten_pulse   <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      if (acc5)  mem[wp]     <= 1'b0;
      if (acc10) mem[wp_ten] <= 1'b1;
      wp          <= wp + AW'(acc5) + AW'(acc10);
      rp          <= rp + AW'(rd);
      fifo_level  <= fifo_level + 4'(acc5) + 4'(acc10) - 4'(rd);
      five_pulse  <= rd && !code;
      ten_pulse   <= rd && code;
      coin_reject <= (hit5 && !acc5) || (hit10 && !acc10);
      if (rd)
        gap <= 3'(GAP_CYCLES);
      else if (gap != 3'd0)
        gap <= gap - 3'd1;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: one default instance and one
// slow-drain instance (D=2, gap 7) to exercise a full queue.
module tb_coin_acceptor;

  logic       clock;
  logic       reset;
  logic       a5, a10, a_en;
  logic       b5, b10, b_en;
  logic       five_a, ten_a, rej_a;
  logic       five_b, ten_b, rej_b;
  logic [3:0] lvl_a, lvl_b;
  int         tests;
  int         fails;

  coin_acceptor dut_a (
    .clock       (clock),
    .reset       (reset),
    .coin5_raw   (a5),
    .coin10_raw  (a10),
    .accept_en   (a_en),
    .five_pulse  (five_a),
    .ten_pulse   (ten_a),
    .coin_reject (rej_a),
    .fifo_level  (lvl_a)
  );

  coin_acceptor #(
    .DEBOUNCE_CYCLES (2),
    .GAP_CYCLES      (7),
    .FIFO_DEPTH      (4)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .coin5_raw   (b5),
    .coin10_raw  (b10),
    .accept_en   (b_en),
    .five_pulse  (five_b),
    .ten_pulse   (ten_b),
    .coin_reject (rej_b),
    .fifo_level  (lvl_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic f, input logic t,
                       input logic r, input logic [3:0] l);
    chk({tag, "_five"}, 4'(five_a), 4'(f));
    chk({tag, "_ten"}, 4'(ten_a), 4'(t));
    chk({tag, "_rej"}, 4'(rej_a), 4'(r));
    chk({tag, "_lvl"}, lvl_a, l);
  endtask

  task automatic chk_b(input string tag, input logic f, input logic t,
                       input logic r, input logic [3:0] l);
    chk({tag, "_five"}, 4'(five_b), 4'(f));
    chk({tag, "_ten"}, 4'(ten_b), 4'(t));
    chk({tag, "_rej"}, 4'(rej_b), 4'(r));
    chk({tag, "_lvl"}, lvl_b, l);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    a5 = 1'b0; a10 = 1'b0; a_en = 1'b1;
    b5 = 1'b0; b10 = 1'b0; b_en = 1'b1;

    repeat (3) tick();
    chk_a("rst_a", 1'b0, 1'b0, 1'b0, 4'd0);
    chk_b("rst_b", 1'b0, 1'b0, 1'b0, 4'd0);
    #2 reset = 1'b1;
    repeat (2) tick();

    // bounce 1,0,1 then held high: one five after edge 7
    a5 = 1'b1; tick();
    a5 = 1'b0; tick();
    a5 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_a("bounce", 1'(k == 7), 1'b0, 1'b0, 4'(k == 6));
    end
    a5 = 1'b0;
    repeat (8) tick();

    // both lines together: five at N, ten at N+2
    a5 = 1'b1; a10 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_a("simul", 1'(k == 7), 1'(k == 9), 1'b0,
            4'(k < 6 ? 0 : k == 6 ? 2 : k < 9 ? 1 : 0));
    end
    a5 = 1'b0; a10 = 1'b0;
    repeat (8) tick();

    // 12 alternating coins through the 4-deep queue
    for (int c = 0; c < 12; c++) begin
      a5  = (c % 2) == 0;
      a10 = (c % 2) == 1;
      for (int k = 1; k <= 8; k++) begin
        if (k == 5) begin
          a5 = 1'b0; a10 = 1'b0;
        end
        tick();
        chk_a("wrap", 1'((c % 2) == 0 && k == 7),
              1'((c % 2) == 1 && k == 7), 1'b0, 4'(k == 6));
      end
    end
    repeat (4) tick();

    // slow drain: queue fills, pair at level 3 rejects the ten
    for (int e = 1; e <= 40; e++) begin
      b5  = (e <= 12) && (((e - 1) % 4) < 2);
      b10 = b5;
      tick();
      chk_b("full", 1'(e == 5 || e == 21 || e == 37),
            1'(e == 13 || e == 29), 1'(e == 12),
            4'(e < 4 ? 0 : e < 5 ? 2 : e < 8 ? 1 : e < 12 ? 3 :
               e < 13 ? 4 : e < 21 ? 3 : e < 29 ? 2 : e < 37 ? 1 : 0));
    end
    repeat (10) tick();

    // acceptance disabled with two queued: ten rejected, queue drains
    for (int e = 1; e <= 28; e++) begin
      b_en = (e <= 8);
      b5   = (e <= 8) && (((e - 1) % 4) < 2);
      b10  = (e <= 4 || (e >= 9 && e <= 12)) && (((e - 1) % 4) < 2);
      tick();
      chk_b("dis", 1'(e == 5 || e == 21), 1'(e == 13), 1'(e == 12),
            4'(e < 4 ? 0 : e < 5 ? 2 : e < 8 ? 1 : e < 13 ? 2 :
               e < 21 ? 1 : 0));
    end
    repeat (10) tick();

    // reset asserted mid-queue at level 3
    b_en = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      b5  = ((e - 1) % 4) < 2;
      b10 = b5;
      tick();
    end
    b5 = 1'b0; b10 = 1'b0;
    chk("pre_rst_lvl", lvl_b, 4'd3);
    #2 reset = 1'b0;
    #1;
    chk_b("async_rst", 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) tick();
    #2 reset = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk_b("post_rst", 1'b0, 1'b0, 1'b0, 4'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
